// File: rtl/hit_resolver.sv
// Collision resolver for the alien-shooter playfield: latches laser/alien and bomb/cannon
// overlaps during the frame scan and commits them to score, lives and the alive matrix in vblank.
module hit_resolver #(
  parameter int unsigned NUM_ROWS    = 5,
  parameter int unsigned NUM_COLUMNS = 8,
  parameter int unsigned SCORE_W     = 14,
  parameter int unsigned START_LIVES = 3,
  parameter int unsigned POINTS_BASE = 10,
  parameter int unsigned POINTS_STEP = 10,
  localparam int unsigned ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int unsigned COL_W   = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1,
  localparam int unsigned CELLS   = NUM_ROWS * NUM_COLUMNS,
  localparam int unsigned LIVES_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               game_reset,
  input  logic               laser_gfx,
  input  logic               alien_pixel,
  input  logic               bomb_gfx,
  input  logic               cannon_gfx,
  input  logic [ROW_W-1:0]   alien_row,
  input  logic [COL_W-1:0]   alien_col,
  output logic [CELLS-1:0]   alive_matrix,
  output logic [SCORE_W-1:0] score,
  output logic [LIVES_W-1:0] lives,
  output logic [3:0]         wave_count,
  output logic               game_over,
  output logic               hit_alien,
  output logic               player_hit,
  output logic               wave_clear
);

  localparam int unsigned IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [32:0] SCORE_MAX = (33'(1) << SCORE_W) - 33'(1);

  typedef enum logic [1:0] {SCAN, COMMIT, CHECK} state_t;

  state_t           state;
  logic             alien_pend;
  logic             player_pend;
  logic [ROW_W-1:0] lat_row;
  logic [COL_W-1:0] lat_col;

  logic [31:0]      row_ext;
  logic [31:0]      col_ext;
  logic             in_range;
  logic [IDX_W-1:0] cell_idx;
  logic [IDX_W-1:0] lat_idx;
  logic             alien_ov;
  logic             player_ov;
  logic [31:0]      row_points;
  logic [32:0]      score_sum;
  logic [SCORE_W-1:0] score_sat;

  // Overlap detection for the pixel currently under the beam; out-of-range coordinates never hit
  assign row_ext   = 32'(alien_row);
  assign col_ext   = 32'(alien_col);
  assign in_range  = (row_ext < NUM_ROWS) && (col_ext < NUM_COLUMNS);
  assign cell_idx  = IDX_W'(row_ext * NUM_COLUMNS + col_ext);
  assign alien_ov  = laser_gfx & alien_pixel & in_range & alive_matrix[cell_idx];
  assign player_ov = bomb_gfx & cannon_gfx;

  // Points for the latched row, top row worth the most, score saturating
  assign lat_idx    = IDX_W'(32'(lat_row) * NUM_COLUMNS + 32'(lat_col));
  assign row_points = POINTS_BASE + POINTS_STEP * (NUM_ROWS - 1 - 32'(lat_row));
  assign score_sum  = 33'(score) + 33'(row_points);
  assign score_sat  = (score_sum > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(score_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SCAN;
      alive_matrix <= {CELLS{1'b1}};
      score        <= '0;
      lives        <= LIVES_W'(START_LIVES);
      wave_count   <= '0;
      game_over    <= 1'b0;
      hit_alien    <= 1'b0;
      player_hit   <= 1'b0;
      wave_clear   <= 1'b0;
      alien_pend   <= 1'b0;
      player_pend  <= 1'b0;
      lat_row      <= '0;
      lat_col      <= '0;
    end else begin
      hit_alien  <= 1'b0;
      player_hit <= 1'b0;
      wave_clear <= 1'b0;
      if (game_reset) begin
        state        <= SCAN;
        alive_matrix <= {CELLS{1'b1}};
        score        <= '0;
        lives        <= LIVES_W'(START_LIVES);
        wave_count   <= '0;
        game_over    <= 1'b0;
        alien_pend   <= 1'b0;
        player_pend  <= 1'b0;
        lat_row      <= '0;
        lat_col      <= '0;
      end else begin
        case (state)
          SCAN: begin
            if (frame_start) begin
              state <= COMMIT;
            end else if (!game_over) begin
              // Only the first alien hit of a frame counts
              if (alien_ov && !alien_pend) begin
                alien_pend <= 1'b1;
                lat_row    <= alien_row;
                lat_col    <= alien_col;
              end
              if (player_ov) player_pend <= 1'b1;
            end
          end
          COMMIT: begin
            state <= CHECK;
            if (!game_over) begin
              if (alien_pend) begin
                alive_matrix <= alive_matrix & ~(CELLS'(1) << lat_idx);
                hit_alien    <= 1'b1;
                score        <= score_sat;
              end
              if (player_pend && (lives != '0)) begin
                lives      <= lives - LIVES_W'(1);
                player_hit <= 1'b1;
              end
            end
          end
          CHECK: begin
            state <= SCAN;
            if (!game_over) begin
              if (alive_matrix == '0) begin
                wave_clear   <= 1'b1;
                alive_matrix <= {CELLS{1'b1}};
                wave_count   <= wave_count + 4'd1;
              end
              if (lives == '0) game_over <= 1'b1;
            end
            alien_pend  <= 1'b0;
            player_pend <= 1'b0;
            lat_row     <= '0;
            lat_col     <= '0;
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule
